bus_port_endpoint: RTL and testbench

- Synthesizable per-port endpoint that sits on the device side of one bus port of bs_gnrtr_n_rbtr.
- It replaces the behavioural driver/monitor FIFO pair used in simulation.
- TX path: the device writes packets into a FIFO; the bus pops them through the pndng/pop/D_pop interface.
- RX path: the bus pushes packets through push/D_push; the endpoint filters them by destination ID into an RX FIFO that the device reads.

---
 rtl/bus_port_endpoint.sv | 101 ++++++++++
 tb/tb_bus_port_endpoint.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bus_port_endpoint.sv
// bus_port_endpoint: device-side bus port with a TX FIFO popped by the bus and an ID-filtered RX FIFO.
module bus_port_endpoint #(
  parameter int pckg_sz = 32,
  parameter int depth = 16,
  parameter logic [7:0] id = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter int cnt_w = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
  output logic [cnt_w-1:0]   drop_cnt,
  output logic               tx_ovf,
  output logic               rx_unf
);
  localparam int pw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth + 1);
  localparam logic [pw-1:0] last = pw'(depth - 1);
  localparam logic [cw-1:0] full_cnt = cw'(depth);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [pw-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [cw-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [cnt_w-1:0] drop_q, drop_d;
  logic pndng_q, tx_full_q, rx_empty_q, tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic tx_do_pop, tx_do_push, rx_do_pop, rx_do_push, match, drop;

  always_comb begin
    tx_do_pop  = pop && (tx_cnt_q != '0);
    tx_do_push = tx_wr && ((tx_cnt_q != full_cnt) || tx_do_pop);
    rx_do_pop  = rx_rd && (rx_cnt_q != '0);
    match      = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast);
    rx_do_push = push && match && ((rx_cnt_q != full_cnt) || rx_do_pop);
    drop       = push && !rx_do_push;
    tx_wp_d    = tx_do_push ? ((tx_wp_q == last) ? '0 : tx_wp_q + 1'b1) : tx_wp_q;
    tx_rp_d    = tx_do_pop ? ((tx_rp_q == last) ? '0 : tx_rp_q + 1'b1) : tx_rp_q;
    rx_wp_d    = rx_do_push ? ((rx_wp_q == last) ? '0 : rx_wp_q + 1'b1) : rx_wp_q;
    rx_rp_d    = rx_do_pop ? ((rx_rp_q == last) ? '0 : rx_rp_q + 1'b1) : rx_rp_q;
    tx_cnt_d   = tx_cnt_q + cw'(tx_do_push) - cw'(tx_do_pop);
    rx_cnt_d   = rx_cnt_q + cw'(rx_do_push) - cw'(rx_do_pop);
    drop_d     = (drop && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
    tx_ovf_d   = tx_ovf_q || (tx_wr && !tx_do_push);
    rx_unf_d   = rx_unf_q || (rx_rd && (rx_cnt_q == '0)) || (pop && (tx_cnt_q == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      drop_q     <= '0;
      pndng_q    <= 1'b0;
      tx_full_q  <= 1'b0;
      rx_empty_q <= 1'b1;
      tx_ovf_q   <= 1'b0;
      rx_unf_q   <= 1'b0;
    end else begin
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_q     <= drop_d;
      pndng_q    <= tx_cnt_d != '0;
      tx_full_q  <= tx_cnt_d == full_cnt;
      rx_empty_q <= rx_cnt_d == '0;
      tx_ovf_q   <= tx_ovf_d;
      rx_unf_q   <= rx_unf_d;
    end
  end

  // Storage needs no reset: counts gate visibility of every entry.
  always_ff @(posedge clk) begin
    if (tx_do_push) tx_mem[tx_wp_q] <= tx_data;
    if (rx_do_push) rx_mem[rx_wp_q] <= D_push;
  end

  assign pndng    = pndng_q;
  assign tx_full  = tx_full_q;
  assign rx_empty = rx_empty_q;
  assign drop_cnt = drop_q;
  assign tx_ovf   = tx_ovf_q;
  assign rx_unf   = rx_unf_q;
  assign D_pop    = tx_mem[tx_rp_q];
  assign rx_data  = rx_mem[rx_rp_q];
endmodule

// File: tb/tb_bus_port_endpoint.sv
// tb_bus_port_endpoint: directed self-checking bench for bus_port_endpoint (id=5, depth=16).
module tb_bus_port_endpoint;
  logic clk = 0, reset, tx_wr, pop, push, rx_rd;
  logic [31:0] tx_data, D_pop, D_push, rx_data;
  logic tx_full, pndng, rx_empty, tx_ovf, rx_unf;
  logic [15:0] drop_cnt;
  int checks = 0, errors = 0;

  bus_port_endpoint #(.pckg_sz(32), .depth(16), .id(8'd5), .broadcast(8'hFF), .cnt_w(16)) dut (
    .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .drop_cnt(drop_cnt),
    .tx_ovf(tx_ovf), .rx_unf(rx_unf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; tx_wr = 0; pop = 0; push = 0; rx_rd = 0; tx_data = '0; D_push = '0;
    tick(); tick();
    reset = 0;
    chk("rst_pndng", 32'(pndng), 0);
    chk("rst_tx_full", 32'(tx_full), 0);
    chk("rst_rx_empty", 32'(rx_empty), 1);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_tx_ovf", 32'(tx_ovf), 0);
    chk("rst_rx_unf", 32'(rx_unf), 0);
    // three writes, three pops
    tx_wr = 1; tx_data = 32'h0100_0001; tick();
    chk("t1_pndng_lat", 32'(pndng), 1);
    chk("t1_head", D_pop, 32'h0100_0001);
    tx_data = 32'h0100_0002; tick();
    tx_data = 32'h0100_0003; tick();
    tx_wr = 0;
    for (int i = 1; i <= 3; i++) begin
      chk("t1_pop_data", D_pop, 32'h0100_0000 + 32'(i));
      pop = 1; tick(); pop = 0;
    end
    chk("t1_pndng_end", 32'(pndng), 0);
    // fill TX, overflow, then write with concurrent pop while full
    for (int i = 0; i < 16; i++) begin
      tx_wr = 1; tx_data = 32'hA000_0000 + 32'(i); tick();
    end
    tx_wr = 0;
    chk("t2_full", 32'(tx_full), 1);
    chk("t2_ovf_pre", 32'(tx_ovf), 0);
    tx_wr = 1; tx_data = 32'hDEAD_0000; tick(); tx_wr = 0;
    chk("t2_ovf", 32'(tx_ovf), 1);
    chk("t2_full_ovf", 32'(tx_full), 1);
    chk("t2_head_ovf", D_pop, 32'hA000_0000);
    tx_wr = 1; tx_data = 32'hBEEF_0001; pop = 1; tick(); tx_wr = 0; pop = 0;
    chk("t2_full_wrpop", 32'(tx_full), 1);
    for (int i = 1; i < 17; i++) begin
      chk("t2_readback", D_pop, (i == 16) ? 32'hBEEF_0001 : 32'hA000_0000 + 32'(i));
      pop = 1; tick(); pop = 0;
    end
    chk("t2_pndng_end", 32'(pndng), 0);
    chk("t2_ovf_sticky", 32'(tx_ovf), 1);
    chk("t2_unf_clear", 32'(rx_unf), 0);
    // RX filter with id=5
    push = 1; D_push = 32'h0500_00AA; tick();
    chk("t3_empty_lat", 32'(rx_empty), 0);
    D_push = 32'hFF00_00BB; tick();
    D_push = 32'h0700_00CC; tick(); push = 0;
    chk("t3_drop", 32'(drop_cnt), 1);
    chk("t3_rx0", rx_data, 32'h0500_00AA);
    rx_rd = 1; tick();
    chk("t3_rx1", rx_data, 32'hFF00_00BB);
    tick(); rx_rd = 0;
    chk("t3_empty_end", 32'(rx_empty), 1);
    // fill RX, drop when full, accept with concurrent read
    for (int i = 0; i < 16; i++) begin
      push = 1; D_push = 32'h0500_0100 + 32'(i); tick();
    end
    push = 0;
    chk("t4_drop_pre", 32'(drop_cnt), 1);
    push = 1; D_push = 32'h0500_0200; tick(); push = 0;
    chk("t4_drop_full", 32'(drop_cnt), 2);
    push = 1; D_push = 32'h0500_0300; rx_rd = 1; tick(); push = 0; rx_rd = 0;
    chk("t4_drop_rdpush", 32'(drop_cnt), 2);
    for (int i = 1; i < 17; i++) begin
      chk("t4_readback", rx_data, (i == 16) ? 32'h0500_0300 : 32'h0500_0100 + 32'(i));
      rx_rd = 1; tick(); rx_rd = 0;
    end
    chk("t4_empty_end", 32'(rx_empty), 1);
    // underflow sources and empty-FIFO simultaneous cases
    pop = 1; tick(); pop = 0;
    chk("t5_unf_pop", 32'(rx_unf), 1);
    chk("t5_pndng", 32'(pndng), 0);
    rx_rd = 1; tick(); rx_rd = 0;
    chk("t5_unf_rd", 32'(rx_unf), 1);
    chk("t5_rx_empty", 32'(rx_empty), 1);
    push = 1; D_push = 32'h0500_0400; rx_rd = 1; tick(); push = 0; rx_rd = 0;
    chk("t5_pushrd_empty", 32'(rx_empty), 0);
    chk("t5_pushrd_data", rx_data, 32'h0500_0400);
    tx_wr = 1; tx_data = 32'h1111_0000; pop = 1; tick(); tx_wr = 0; pop = 0;
    chk("t5_wrpop_pndng", 32'(pndng), 1);
    chk("t5_wrpop_data", D_pop, 32'h1111_0000);
    // reset mid-operation, with a competing write held high
    reset = 1; tx_wr = 1; tx_data = 32'h2222_0000; tick(); reset = 0; tx_wr = 0;
    chk("r_pndng", 32'(pndng), 0);
    chk("r_rx_empty", 32'(rx_empty), 1);
    chk("r_rx_unf", 32'(rx_unf), 0);
    chk("r_drop", 32'(drop_cnt), 0);
    chk("r_tx_ovf", 32'(tx_ovf), 0);
    chk("r_tx_full", 32'(tx_full), 0);
    // wrap-around at full rate on both FIFOs
    tx_wr = 1; tx_data = 32'hC000_0000; push = 1; D_push = 32'h05D0_0000; tick();
    for (int i = 0; i < 40; i++) begin
      chk("t6_tx_order", D_pop, 32'hC000_0000 + 32'(i));
      chk("t6_rx_order", rx_data, 32'h05D0_0000 + 32'(i));
      tx_data = 32'hC000_0000 + 32'(i + 1); pop = 1;
      D_push = 32'h05D0_0000 + 32'(i + 1); rx_rd = 1;
      tick();
    end
    tx_wr = 0; push = 0;
    chk("t6_tx_last", D_pop, 32'hC000_0028);
    chk("t6_rx_last", rx_data, 32'h05D0_0028);
    tick(); pop = 0; rx_rd = 0;
    chk("t6_pndng_end", 32'(pndng), 0);
    chk("t6_empty_end", 32'(rx_empty), 1);
    chk("t6_drop_end", 32'(drop_cnt), 0);
    chk("t6_unf_end", 32'(rx_unf), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
